// File: rtl/pipe_hold_if.sv
// Request/response bundle between the pipeline stages and the hold controller.
// master = stage side (drives requests), slave = controller.
interface pipe_hold_if #(
    parameter int CNT_W = 32
);
    logic             jump_req_i;
    logic [31:0]      jump_addr_i;
    logic             ld_hazard_i;
    logic             bus_wait_i;
    logic             mdiv_start_i;
    logic             mdiv_done_i;
    logic [2:0]       hold_flag_o;
    logic             jump_o;
    logic [31:0]      jump_addr_o;
    logic             mdiv_abort_o;
    logic             mdiv_err_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output jump_req_i, jump_addr_i, ld_hazard_i, bus_wait_i, mdiv_start_i, mdiv_done_i,
        input  hold_flag_o, jump_o, jump_addr_o, mdiv_abort_o, mdiv_err_o, stall_cnt_o
    );
    modport slave (
        input  jump_req_i, jump_addr_i, ld_hazard_i, bus_wait_i, mdiv_start_i, mdiv_done_i,
        output hold_flag_o, jump_o, jump_addr_o, mdiv_abort_o, mdiv_err_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold sequencer: merges stall/flush requests into one hold level,
// runs the jump-flush and mul/div-wait sequences, counts stalled cycles.
module pipe_hold_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MDIV_TIMEOUT = 64,
    parameter int CNT_W        = 32
) (
    input  logic       clk,
    input  logic       rst,
    pipe_hold_if.slave bus
);
    localparam logic [2:0] PAUSE_NONE = 3'd0;
    localparam logic [2:0] PAUSE_IF   = 3'd2;
    localparam logic [2:0] PAUSE_ID   = 3'd3;
    localparam int SEQ_W = $clog2((MDIV_TIMEOUT > 16) ? MDIV_TIMEOUT : 16) + 1;

    typedef enum logic [1:0] {S_RUN, S_MDIV, S_FLUSH} state_t;

    state_t           state, state_n, jump_next;
    logic [SEQ_W-1:0] cnt, cnt_n;
    logic [2:0]       hold;
    logic             jump, abort, err_set, err;
    logic [31:0]      jaddr;
    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RUN;
            cnt       <= '0;
            err       <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (err_set)
                err <= 1'b1;
            if (hold != PAUSE_NONE)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        hold      = PAUSE_NONE;
        jump      = 1'b0;
        jaddr     = 32'd0;
        abort     = 1'b0;
        err_set   = 1'b0;
        jump_next = (FLUSH_CYCLES > 0) ? S_FLUSH : S_RUN;
        case (state)
            S_RUN: begin
                if (bus.bus_wait_i)  hold = PAUSE_IF;
                if (bus.ld_hazard_i) hold = PAUSE_ID;
                if (bus.mdiv_start_i) begin
                    hold    = PAUSE_ID;
                    state_n = S_MDIV;
                    cnt_n   = '0;
                end
            end
            S_MDIV: begin
                // ld_hazard_i is irrelevant here: ID is frozen for the whole wait
                hold  = PAUSE_ID;
                cnt_n = cnt + SEQ_W'(1);
                if (bus.mdiv_done_i) begin
                    hold    = bus.bus_wait_i ? PAUSE_IF : PAUSE_NONE;
                    state_n = S_RUN;
                end else if (cnt == SEQ_W'(MDIV_TIMEOUT - 1)) begin
                    abort   = 1'b1;
                    err_set = 1'b1;
                    hold    = bus.bus_wait_i ? PAUSE_IF : PAUSE_NONE;
                    state_n = S_RUN;
                end
                if (bus.jump_req_i && !bus.mdiv_done_i)
                    abort = 1'b1;
            end
            S_FLUSH: begin
                // a stalled fetch did not complete, so it does not count toward the flush
                hold = PAUSE_IF;
                if (!bus.bus_wait_i) begin
                    cnt_n = cnt + SEQ_W'(1);
                    if (cnt == SEQ_W'(FLUSH_CYCLES - 1))
                        state_n = S_RUN;
                end
            end
            default: state_n = S_RUN;
        endcase
        // a taken jump overrides every sequence and squashes a same-cycle mdiv issue
        if (bus.jump_req_i) begin
            jump    = 1'b1;
            jaddr   = bus.jump_addr_i;
            hold    = PAUSE_ID;
            state_n = jump_next;
            cnt_n   = '0;
        end
        if (rst) begin
            hold  = PAUSE_NONE;
            jump  = 1'b0;
            jaddr = 32'd0;
            abort = 1'b0;
        end
    end

    assign bus.hold_flag_o  = hold;
    assign bus.jump_o       = jump;
    assign bus.jump_addr_o  = jaddr;
    assign bus.mdiv_abort_o = abort;
    assign bus.mdiv_err_o   = err;
    assign bus.stall_cnt_o  = stall_cnt;
endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed bench for pipe_hold_ctrl; a 4-bit-counter instance exercises counter wrap.
module tb_pipe_hold_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pipe_hold_if #(.CNT_W(32)) ifc ();
    pipe_hold_if #(.CNT_W(4))  ifw ();

    pipe_hold_ctrl #(.FLUSH_CYCLES(1), .MDIV_TIMEOUT(64), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .bus(ifc.slave));
    pipe_hold_ctrl #(.FLUSH_CYCLES(1), .MDIV_TIMEOUT(64), .CNT_W(4)) u_dut_w (
        .clk(clk), .rst(rst), .bus(ifw.slave));

    task automatic clear_inputs();
        ifc.jump_req_i = 0; ifc.jump_addr_i = 0; ifc.ld_hazard_i = 0;
        ifc.bus_wait_i = 0; ifc.mdiv_start_i = 0; ifc.mdiv_done_i = 0;
        ifw.jump_req_i = 0; ifw.jump_addr_i = 0; ifw.ld_hazard_i = 0;
        ifw.bus_wait_i = 0; ifw.mdiv_start_i = 0; ifw.mdiv_done_i = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1; clear_inputs();
        @(negedge clk); rst = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1; ifc.jump_req_i = 1; ifc.jump_addr_i = 32'h100; ifc.ld_hazard_i = 1; ifc.mdiv_start_i = 1;
        #1;
        n_cmp++; if (ifc.hold_flag_o !== 3'd0) begin n_bad++; $display("FAIL rst_hold got %0d want 0", ifc.hold_flag_o); end
        n_cmp++; if (ifc.jump_o !== 1'b0) begin n_bad++; $display("FAIL rst_jump got %b want 0", ifc.jump_o); end
        n_cmp++; if (ifc.jump_addr_o !== 32'd0) begin n_bad++; $display("FAIL rst_addr got %h want 0", ifc.jump_addr_o); end
        @(negedge clk); clear_inputs(); #1;
        n_cmp++; if (ifc.stall_cnt_o !== 32'd0) begin n_bad++; $display("FAIL rst_stall got %0d want 0", ifc.stall_cnt_o); end
        n_cmp++; if (ifc.mdiv_err_o !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", ifc.mdiv_err_o); end
        n_cmp++; if (ifc.mdiv_abort_o !== 1'b0) begin n_bad++; $display("FAIL rst_abort got %b want 0", ifc.mdiv_abort_o); end
        rst = 0;
    endtask

    task automatic test_jump();
        do_reset();
        @(negedge clk); ifc.jump_req_i = 1; ifc.jump_addr_i = 32'h0000_0100; #1;
        n_cmp++; if (ifc.jump_o !== 1'b1) begin n_bad++; $display("FAIL jmp_strobe got %b want 1", ifc.jump_o); end
        n_cmp++; if (ifc.jump_addr_o !== 32'h100) begin n_bad++; $display("FAIL jmp_addr got %h want 100", ifc.jump_addr_o); end
        n_cmp++; if (ifc.hold_flag_o !== 3'd3) begin n_bad++; $display("FAIL jmp_hold0 got %0d want 3", ifc.hold_flag_o); end
        @(negedge clk); ifc.jump_req_i = 0; ifc.jump_addr_i = 32'hDEAD_BEEF; #1;
        n_cmp++; if (ifc.hold_flag_o !== 3'd2) begin n_bad++; $display("FAIL jmp_hold1 got %0d want 2", ifc.hold_flag_o); end
        n_cmp++; if (ifc.jump_addr_o !== 32'd0) begin n_bad++; $display("FAIL jmp_addr_idle got %h want 0", ifc.jump_addr_o); end
        @(negedge clk); #1;
        n_cmp++; if (ifc.hold_flag_o !== 3'd0) begin n_bad++; $display("FAIL jmp_hold2 got %0d want 0", ifc.hold_flag_o); end
        n_cmp++; if (ifc.stall_cnt_o !== 32'd2) begin n_bad++; $display("FAIL jmp_stall got %0d want 2", ifc.stall_cnt_o); end
        clear_inputs();
    endtask

    task automatic test_mdiv_done();
        do_reset();
        @(negedge clk); ifc.mdiv_start_i = 1; #1;
        n_cmp++; if (ifc.hold_flag_o !== 3'd3) begin n_bad++; $display("FAIL md_hold_start got %0d want 3", ifc.hold_flag_o); end
        for (int i = 1; i < 10; i++) begin
            @(negedge clk); ifc.mdiv_start_i = 0; ifc.ld_hazard_i = (i == 4); #1;
            n_cmp++; if (ifc.hold_flag_o !== 3'd3) begin n_bad++; $display("FAIL md_hold_c%0d got %0d want 3", i, ifc.hold_flag_o); end
        end
        @(negedge clk); ifc.ld_hazard_i = 0; ifc.mdiv_done_i = 1; #1;
        n_cmp++; if (ifc.hold_flag_o !== 3'd0) begin n_bad++; $display("FAIL md_hold_done got %0d want 0", ifc.hold_flag_o); end
        n_cmp++; if (ifc.stall_cnt_o !== 32'd10) begin n_bad++; $display("FAIL md_stall got %0d want 10", ifc.stall_cnt_o); end
        n_cmp++; if (ifc.mdiv_abort_o !== 1'b0) begin n_bad++; $display("FAIL md_abort got %b want 0", ifc.mdiv_abort_o); end
        @(negedge clk); ifc.mdiv_done_i = 0; #1;
        n_cmp++; if (ifc.hold_flag_o !== 3'd0) begin n_bad++; $display("FAIL md_hold_after got %0d want 0", ifc.hold_flag_o); end
    endtask

    // leaves mdiv_err_o set so test_rst_mid can see it cleared
    task automatic test_mdiv_timeout();
        do_reset();
        @(negedge clk); ifc.mdiv_start_i = 1; #1;
        n_cmp++; if (ifc.hold_flag_o !== 3'd3) begin n_bad++; $display("FAIL to_hold_start got %0d want 3", ifc.hold_flag_o); end
        for (int i = 1; i < 64; i++) begin
            @(negedge clk); ifc.mdiv_start_i = 0; #1;
            n_cmp++; if (ifc.hold_flag_o !== 3'd3 || ifc.mdiv_abort_o !== 1'b0) begin
                n_bad++; $display("FAIL to_wait_c%0d hold %0d abort %b want 3/0", i, ifc.hold_flag_o, ifc.mdiv_abort_o); end
        end
        @(negedge clk); #1;
        n_cmp++; if (ifc.mdiv_abort_o !== 1'b1) begin n_bad++; $display("FAIL to_abort got %b want 1", ifc.mdiv_abort_o); end
        n_cmp++; if (ifc.hold_flag_o !== 3'd0) begin n_bad++; $display("FAIL to_hold got %0d want 0", ifc.hold_flag_o); end
        n_cmp++; if (ifc.stall_cnt_o !== 32'd64) begin n_bad++; $display("FAIL to_stall got %0d want 64", ifc.stall_cnt_o); end
        @(negedge clk); #1;
        n_cmp++; if (ifc.mdiv_abort_o !== 1'b0) begin n_bad++; $display("FAIL to_abort_pulse got %b want 0", ifc.mdiv_abort_o); end
        n_cmp++; if (ifc.mdiv_err_o !== 1'b1) begin n_bad++; $display("FAIL to_err got %b want 1", ifc.mdiv_err_o); end
        repeat (5) @(negedge clk);
        #1;
        n_cmp++; if (ifc.mdiv_err_o !== 1'b1) begin n_bad++; $display("FAIL to_err_sticky got %b want 1", ifc.mdiv_err_o); end
    endtask

    task automatic test_mdiv_jump();
        do_reset();
        @(negedge clk); ifc.mdiv_start_i = 1;
        for (int i = 1; i < 5; i++) begin @(negedge clk); ifc.mdiv_start_i = 0; end
        @(negedge clk); ifc.jump_req_i = 1; ifc.jump_addr_i = 32'h200; #1;
        n_cmp++; if (ifc.mdiv_abort_o !== 1'b1) begin n_bad++; $display("FAIL mj_abort got %b want 1", ifc.mdiv_abort_o); end
        n_cmp++; if (ifc.jump_o !== 1'b1 || ifc.jump_addr_o !== 32'h200) begin
            n_bad++; $display("FAIL mj_jump got %b/%h want 1/200", ifc.jump_o, ifc.jump_addr_o); end
        @(negedge clk); ifc.jump_req_i = 0; #1;
        n_cmp++; if (ifc.hold_flag_o !== 3'd2 || ifc.mdiv_abort_o !== 1'b0) begin
            n_bad++; $display("FAIL mj_flush hold %0d abort %b want 2/0", ifc.hold_flag_o, ifc.mdiv_abort_o); end
        @(negedge clk); #1;
        n_cmp++; if (ifc.hold_flag_o !== 3'd0) begin n_bad++; $display("FAIL mj_run got %0d want 0", ifc.hold_flag_o); end
        // jump and done together: mul/div completes normally, jump still taken
        @(negedge clk); ifc.mdiv_start_i = 1;
        for (int i = 1; i < 3; i++) begin @(negedge clk); ifc.mdiv_start_i = 0; end
        @(negedge clk); ifc.jump_req_i = 1; ifc.mdiv_done_i = 1; ifc.jump_addr_i = 32'h300; #1;
        n_cmp++; if (ifc.mdiv_abort_o !== 1'b0) begin n_bad++; $display("FAIL mjd_abort got %b want 0", ifc.mdiv_abort_o); end
        n_cmp++; if (ifc.jump_o !== 1'b1 || ifc.hold_flag_o !== 3'd3) begin
            n_bad++; $display("FAIL mjd_jump got %b/%0d want 1/3", ifc.jump_o, ifc.hold_flag_o); end
        @(negedge clk); clear_inputs(); #1;
        n_cmp++; if (ifc.hold_flag_o !== 3'd2) begin n_bad++; $display("FAIL mjd_flush got %0d want 2", ifc.hold_flag_o); end
        @(negedge clk); #1;
        n_cmp++; if (ifc.hold_flag_o !== 3'd0) begin n_bad++; $display("FAIL mjd_run got %0d want 0", ifc.hold_flag_o); end
    endtask

    task automatic test_ld_bus();
        logic [2:0] exp_hold [4] = '{3'd3, 3'd2, 3'd3, 3'd0};
        logic       ld_v     [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic       bw_v     [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); ifc.ld_hazard_i = ld_v[i]; ifc.bus_wait_i = bw_v[i]; #1;
            n_cmp++; if (ifc.hold_flag_o !== exp_hold[i]) begin
                n_bad++; $display("FAIL ldbus_v%0d got %0d want %0d", i, ifc.hold_flag_o, exp_hold[i]); end
        end
        // flush: bus_wait freezes the count, mdiv_start is dropped
        @(negedge clk); ifc.jump_req_i = 1; ifc.jump_addr_i = 32'h40;
        @(negedge clk); ifc.jump_req_i = 0; ifc.bus_wait_i = 1; #1;
        n_cmp++; if (ifc.hold_flag_o !== 3'd2) begin n_bad++; $display("FAIL fl_bus got %0d want 2", ifc.hold_flag_o); end
        @(negedge clk); ifc.bus_wait_i = 0; ifc.mdiv_start_i = 1; #1;
        n_cmp++; if (ifc.hold_flag_o !== 3'd2) begin n_bad++; $display("FAIL fl_frozen got %0d want 2", ifc.hold_flag_o); end
        @(negedge clk); ifc.mdiv_start_i = 0; #1;
        n_cmp++; if (ifc.hold_flag_o !== 3'd0) begin n_bad++; $display("FAIL fl_exit got %0d want 0", ifc.hold_flag_o); end
        // second jump inside the flush restarts it
        @(negedge clk); ifc.jump_req_i = 1; ifc.jump_addr_i = 32'h80;
        @(negedge clk); ifc.jump_addr_i = 32'hC0; #1;
        n_cmp++; if (ifc.hold_flag_o !== 3'd3 || ifc.jump_addr_o !== 32'hC0) begin
            n_bad++; $display("FAIL fl_rejump got %0d/%h want 3/c0", ifc.hold_flag_o, ifc.jump_addr_o); end
        @(negedge clk); ifc.jump_req_i = 0; #1;
        n_cmp++; if (ifc.hold_flag_o !== 3'd2) begin n_bad++; $display("FAIL fl_restart got %0d want 2", ifc.hold_flag_o); end
        @(negedge clk); #1;
        n_cmp++; if (ifc.hold_flag_o !== 3'd0) begin n_bad++; $display("FAIL fl_done got %0d want 0", ifc.hold_flag_o); end
        clear_inputs();
    endtask

    task automatic test_rst_mid();
        @(negedge clk); ifc.mdiv_start_i = 1;
        for (int i = 1; i < 3; i++) begin @(negedge clk); ifc.mdiv_start_i = 0; end
        @(negedge clk); rst = 1; #1;
        n_cmp++; if (ifc.mdiv_abort_o !== 1'b0 || ifc.hold_flag_o !== 3'd0) begin
            n_bad++; $display("FAIL rm_during abort %b hold %0d want 0/0", ifc.mdiv_abort_o, ifc.hold_flag_o); end
        @(negedge clk); rst = 0; #1;
        n_cmp++; if (ifc.hold_flag_o !== 3'd0) begin n_bad++; $display("FAIL rm_hold got %0d want 0", ifc.hold_flag_o); end
        n_cmp++; if (ifc.stall_cnt_o !== 32'd0) begin n_bad++; $display("FAIL rm_stall got %0d want 0", ifc.stall_cnt_o); end
        n_cmp++; if (ifc.mdiv_err_o !== 1'b0) begin n_bad++; $display("FAIL rm_err got %b want 0", ifc.mdiv_err_o); end
        n_cmp++; if (ifc.mdiv_abort_o !== 1'b0) begin n_bad++; $display("FAIL rm_abort got %b want 0", ifc.mdiv_abort_o); end
    endtask

    task automatic test_stall_wrap();
        do_reset();
        for (int i = 0; i < 15; i++) begin @(negedge clk); ifw.bus_wait_i = 1; end
        #1;
        n_cmp++; if (ifw.hold_flag_o !== 3'd2) begin n_bad++; $display("FAIL wr_hold got %0d want 2", ifw.hold_flag_o); end
        @(negedge clk); #1;
        n_cmp++; if (ifw.stall_cnt_o !== 4'hF) begin n_bad++; $display("FAIL wr_max got %0d want 15", ifw.stall_cnt_o); end
        @(negedge clk); ifw.bus_wait_i = 0; #1;
        n_cmp++; if (ifw.stall_cnt_o !== 4'h0) begin n_bad++; $display("FAIL wr_wrap got %0d want 0", ifw.stall_cnt_o); end
        @(negedge clk); #1;
        n_cmp++; if (ifw.stall_cnt_o !== 4'h0) begin n_bad++; $display("FAIL wr_idle got %0d want 0", ifw.stall_cnt_o); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_jump();
        test_mdiv_done();
        test_mdiv_timeout();
        test_rst_mid();
        test_mdiv_jump();
        test_ld_bus();
        test_stall_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
